adc_capture_buffer: RTL



---
 rtl/adc_capture_buffer_if.sv | 23 ++
 rtl/adc_capture_buffer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/adc_capture_buffer_if.sv
// Sample-path bundle for adc_capture_buffer: ADC write stream in, valid/ready readout stream out.
// master = ADC source / downstream consumer side, slave = capture buffer.
interface adc_capture_buffer_if #(
    parameter int DATA_W = 10
);
    logic              adc_valid;
    logic [DATA_W-1:0] adc_data;
    logic              trig;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;

    modport master (
        output adc_valid, adc_data, trig, rd_ready,
        input  rd_valid, rd_data, rd_last
    );

    modport slave (
        input  adc_valid, adc_data, trig, rd_ready,
        output rd_valid, rd_data, rd_last
    );
endinterface

// File: rtl/adc_capture_buffer.sv
// Pre/post-trigger circular capture buffer: records ADC samples once armed, freezes a DEPTH-sample
// window around the trigger and streams it oldest-first through a 2-entry output skid buffer.
module adc_capture_buffer #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 5120,
    parameter int ADDR_W = 13,
    parameter int PRE    = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arm,
    input  logic abort,
    output logic busy,
    output logic done,
    adc_capture_buffer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FILL, WAIT_TRIG, POST, READ} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PRE_M1    = ADDR_W'(PRE - 1);
    localparam logic [ADDR_W-1:0] POST_LEN  = ADDR_W'(DEPTH - PRE - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   ISSUE_END = (ADDR_W + 1)'(DEPTH - 1);

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_q;
    logic              ram_vld, ram_last;

    logic [ADDR_W-1:0] wr_ptr, rd_ptr, fill_cnt, post_cnt;
    logic [ADDR_W-1:0] wr_ptr_inc, rd_ptr_inc;
    logic [ADDR_W:0]   issue_cnt;

    logic              out_valid, out_last, skid_valid, skid_last;
    logic [DATA_W-1:0] out_data, skid_data;

    logic       wr_en, pop, final_hs, room, issue_en, enter_read;
    logic [1:0] occ;

    assign wr_ptr_inc = (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + ONE;
    assign rd_ptr_inc = (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + ONE;

    assign wr_en    = bus.adc_valid && !abort &&
                      (state == FILL || state == WAIT_TRIG || state == POST);
    assign pop      = out_valid && bus.rd_ready;
    assign final_hs = pop && out_last;

    // Reads in flight plus buffered entries never exceed the two skid slots.
    assign occ        = 2'(out_valid) + 2'(skid_valid) + 2'(ram_vld);
    assign room       = (occ < 2'd2) || (pop && (occ == 2'd2));
    assign issue_en   = (state == READ) && !abort && (issue_cnt != DEPTH_C) && room;
    assign enter_read = (state != READ) && (state_nxt == READ);

    assign busy         = (state != IDLE);
    assign bus.rd_valid = out_valid;
    assign bus.rd_last  = out_valid && out_last;
    assign bus.rd_data  = out_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:      if (arm) state_nxt = FILL;
                FILL:      if (bus.adc_valid && fill_cnt == PRE_M1) state_nxt = WAIT_TRIG;
                WAIT_TRIG: if (bus.adc_valid && bus.trig)
                               state_nxt = (POST_LEN == '0) ? READ : POST;
                POST:      if (bus.adc_valid && post_cnt == ONE) state_nxt = READ;
                READ:      if (final_hs) state_nxt = IDLE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= bus.adc_data;
        if (issue_en) ram_q <= mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_cnt   <= '0;
            post_cnt   <= '0;
            issue_cnt  <= '0;
            ram_vld    <= 1'b0;
            ram_last   <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_last  <= 1'b0;
            skid_data  <= '0;
            done       <= 1'b0;
        end else if (abort) begin
            ram_vld    <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            skid_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= (state == READ) && final_hs;

            if (state == IDLE && arm) begin
                wr_ptr   <= '0;
                fill_cnt <= '0;
            end
            if (wr_en) wr_ptr <= wr_ptr_inc;
            if (state == FILL && bus.adc_valid) fill_cnt <= fill_cnt + ONE;
            if (state == WAIT_TRIG && bus.adc_valid && bus.trig) post_cnt <= POST_LEN;
            if (state == POST && bus.adc_valid) post_cnt <= post_cnt - ONE;

            // Entry into READ always coincides with the final write, so the oldest sample sits at wr_ptr_inc.
            if (enter_read) begin
                rd_ptr    <= wr_ptr_inc;
                issue_cnt <= '0;
            end else if (issue_en) begin
                rd_ptr    <= rd_ptr_inc;
                issue_cnt <= issue_cnt + 1'b1;
            end

            ram_vld  <= issue_en;
            ram_last <= issue_en && (issue_cnt == ISSUE_END);

            if (pop || !out_valid) begin
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    out_data   <= skid_data;
                    out_last   <= skid_last;
                    skid_valid <= ram_vld;
                    skid_data  <= ram_q;
                    skid_last  <= ram_last;
                end else begin
                    out_valid <= ram_vld;
                    out_last  <= ram_vld && ram_last;
                    if (ram_vld) out_data <= ram_q;
                end
            end else if (ram_vld) begin
                skid_valid <= 1'b1;
                skid_data  <= ram_q;
                skid_last  <= ram_last;
            end
        end
    end
endmodule
